// File: rtl/regfile_writeback.sv
// Register-file write-port arbiter: the ALU result has priority, and memory/mul
// results wait in an in-order queue. Same-address ALU writes kill queued entries.
module regfile_writeback #(
    parameter int DEPTH = 4,
    parameter int AW    = 5,
    parameter int DW    = 32
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       alu_valid,
    input  logic [AW-1:0]              alu_waddr,
    input  logic [DW-1:0]              alu_wdata,
    input  logic                       mem_valid,
    output logic                       mem_ready,
    input  logic [AW-1:0]              mem_waddr,
    input  logic [DW-1:0]              mem_wdata,
    output logic                       rf_we,
    output logic [AW-1:0]              rf_waddr,
    output logic [DW-1:0]              rf_wdata,
    input  logic [AW-1:0]              chk_addr,
    output logic                       chk_pending,
    output logic [$clog2(DEPTH):0]     q_count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [DEPTH-1:0]  q_live;
    logic [AW-1:0]     q_addr [DEPTH];
    logic [DW-1:0]     q_data [DEPTH];
    logic [PW-1:0]     head;
    logic [PW-1:0]     tail;
    logic [CW-1:0]     count;

    logic alu_wr;
    logic push;
    logic push_live;
    logic pop;

    assign mem_ready = !reset && (count < CW'(DEPTH));
    assign alu_wr    = alu_valid && (alu_waddr != '0);
    // Writes to r0 complete the handshake but are dropped before the queue.
    assign push      = mem_valid && mem_ready && (mem_waddr != '0);
    assign push_live = !(alu_wr && (alu_waddr == mem_waddr));
    assign pop       = !alu_valid && (count != '0);
    assign q_count   = count;

    // A live bit is set only while its slot holds an unpopped, unkilled entry.
    always_comb begin
        chk_pending = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (q_live[i] && (q_addr[i] == chk_addr))
                chk_pending = 1'b1;
        end
        if (chk_addr == '0)
            chk_pending = 1'b0;
    end

    // NOTE: payload storage has no reset; a slot's contents are only ever
    // observed while its live bit (which is reset) marks it valid.
    always_ff @(posedge clk) begin
        if (push) begin
            q_addr[tail] <= mem_waddr;
            q_data[tail] <= mem_wdata;
        end
    end

    // NOTE: all sequential state uses non-blocking assignments so every
    // right-hand side sees pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            q_live   <= '0;
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            rf_we    <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (alu_wr && (q_addr[i] == alu_waddr))
                    q_live[i] <= 1'b0;
            end

            if (pop) begin
                q_live[head] <= 1'b0;
                head         <= head + PW'(1);
            end

            if (push) begin
                q_live[tail] <= push_live;
                tail         <= tail + PW'(1);
            end

            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase

            if (alu_valid) begin
                rf_we <= alu_wr;
                if (alu_wr) begin
                    rf_waddr <= alu_waddr;
                    rf_wdata <= alu_wdata;
                end
            end else if (pop) begin
                rf_we <= q_live[head];
                if (q_live[head]) begin
                    rf_waddr <= q_addr[head];
                    rf_wdata <= q_data[head];
                end
            end else begin
                rf_we <= 1'b0;
            end
        end
    end

endmodule
